regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file with a sequential clear engine, per-register pending-write scoreboard, and optional write-to-read bypass. It sits in the decode/writeback boundary of the core pipeline. Decode reads operands and reserves destinations. Writeback commits results and releases reservations. The clear engine replaces a single-cycle array reset with a one-register-per-cycle sweep.

## Interface
- WORD_SIZE, 32, data word width
- INDEX_WIDTH, 4, register index width; NUM_REGS = 2**INDEX_WIDTH, all entries usable
- NUM_READ, 2, number of combinational read ports (1..8)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock
- clrReq  in  1  request a full clear sweep (sampled when rdy=1)
- rdy  out  1  array valid; writes/reserves accepted only when 1
- wrtEn  in  1  write strobe
- wrtRegno  in  INDEX_WIDTH  write index
- dataIn  in  WORD_SIZE  write data
- rsvEn  in  1  reserve strobe (mark destination pending)
- rsvRegno  in  INDEX_WIDTH  reserve index
- regno  in  NUM_READ*INDEX_WIDTH  read indices, port k at bits [k*INDEX_WIDTH +: INDEX_WIDTH]
- dataOut  out  NUM_READ*WORD_SIZE  read data, same packing
- busy  out  NUM_READ  pending flag of each read port's register

## Operation
- FSM states: CLEAR, READY. Reset asserted: state=CLEAR, sweep counter=0, busy bits all 0, rdy=0.
- CLEAR: each cycle write 0 to entry[counter], counter+1. When counter=NUM_REGS-1 is written, go to READY next edge. Sweep takes exactly NUM_REGS cycles after reset release.
- READY: rdy=1. clrReq=1 -> CLEAR next edge, counter=0, all busy bits cleared.
- clrReq during CLEAR: ignored; the sweep is not restarted.
- Write: wrtEn & rdy -> entry[wrtRegno] <= dataIn, busy[wrtRegno] <= 0. Writes while rdy=0 are dropped silently.
- Reserve: rsvEn & rdy -> busy[rsvRegno] <= 1. Reserves while rdy=0 are dropped.
- Write and reserve to the same index in the same cycle: data written, busy ends 1 (reserve wins: new producer).
- clrReq with wrtEn/rsvEn in the same READY cycle: write/reserve take effect, then the sweep zeros the entry and busy is cleared at the CLEAR transition.
- Reads: combinational; dataOut[k] = entry[regno[k]]. While rdy=0, all dataOut forced 0 and all busy outputs forced 0.
- Reset asserted mid-sweep or mid-operation: immediate return to CLEAR/counter 0; array contents unspecified until the new sweep finishes.

## Timing
- Read latency 0 (combinational from regno and state).
- Write visible on the read ports the cycle after the wrtEn edge (without bypass).
- busy set/clear visible the cycle after the strobe edge.
- rdy rises NUM_REGS+0 cycles after the first rising edge with reset high, i.e. rdy=1 in cycle NUM_REGS (cycle 0 = first clear write).
- clrReq at edge t: rdy=0 from t+1 through t+NUM_REGS, rdy=1 at t+NUM_REGS+1.

## Configuration
- REGFILE_BYPASS_EN defined: when rdy & wrtEn & regno[k]==wrtRegno, dataOut[k]=dataIn and busy[k]=0 in the same cycle (forwarding). If rsvEn targets the same index that cycle, busy[k] still reports 0 until the next edge.
- Undefined: no forwarding; reads return stored array contents only; busy reflects registered state only.

## Test plan
- Reset release, INDEX_WIDTH=4 -> rdy=0 for 16 cycles, rdy=1 on cycle 16; all 16 entries read 0.
- Write 0xDEADBEEF to r5, read r5 on port 1 next cycle -> 0xDEADBEEF; port 0 on r6 -> 0. With REGFILE_BYPASS_EN, the same-cycle read of r5 returns 0xDEADBEEF.
- rsvEn r3, then wrtEn r3 0x12 two cycles later -> busy=1 for two cycles, then 0; same-cycle rsvEn+wrtEn on r7 -> busy r7=1, data=written value.
- clrReq after writing r1..r15 nonzero -> rdy low for 16 cycles; a write issued during CLEAR is dropped; all entries 0 and busy 0 afterwards.
- reset pulsed low at sweep counter=9 -> counter restarts; rdy rises 16 cycles after release.
- NUM_READ=4, all ports reading the same busy register -> all four busy bits 1 and identical dataOut.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a one-entry-per-cycle clear sweep,
// per-register pending scoreboard and optional REGFILE_BYPASS_EN forwarding.
module regfile_mp #(
   parameter int WORD_SIZE   = 32,
   parameter int INDEX_WIDTH = 4,
   parameter int NUM_READ    = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clrReq,
   output logic                            rdy,
   input  logic                            wrtEn,
   input  logic [INDEX_WIDTH-1:0]          wrtRegno,
   input  logic [WORD_SIZE-1:0]            dataIn,
   input  logic                            rsvEn,
   input  logic [INDEX_WIDTH-1:0]          rsvRegno,
   input  logic [NUM_READ*INDEX_WIDTH-1:0] regno,
   output logic [NUM_READ*WORD_SIZE-1:0]   dataOut,
   output logic [NUM_READ-1:0]             busy
);

   localparam int NUM_REGS = 2 ** INDEX_WIDTH;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [INDEX_WIDTH-1:0] cnt;
   logic [WORD_SIZE-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0]    pend;

   assign rdy = (state == READY);

   // state register and sweep counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
      end
   end

   // next state: leave CLEAR after the last entry, re-enter on clrReq
   always_comb begin
      state_nxt = state;
      unique case (state)
         CLEAR: if (cnt == '1) state_nxt = READY;
         READY: if (clrReq) state_nxt = CLEAR;
      endcase
   end

   // array: sweep zeros while clearing, accepted writes while ready
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[cnt] <= '0;
      else if (wrtEn)
         mem[wrtRegno] <= dataIn;
   end

   // pending scoreboard: write releases, reserve claims, clear wipes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
      end else if (state == CLEAR) begin
         pend <= '0;
      end else if (clrReq) begin
         pend <= '0;
      end else begin
         if (wrtEn)
            pend[wrtRegno] <= 1'b0;
         if (rsvEn)
            pend[rsvRegno] <= 1'b1;
      end
   end

   // read ports, forced to zero while the array is not valid
   always_comb begin
      logic [INDEX_WIDTH-1:0] idx;
      idx     = '0;
      dataOut = '0;
      busy    = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         idx = regno[k*INDEX_WIDTH +: INDEX_WIDTH];
         if (rdy) begin
            dataOut[k*WORD_SIZE +: WORD_SIZE] = mem[idx];
            busy[k] = pend[idx];
`ifdef REGFILE_BYPASS_EN
            if (wrtEn && (idx == wrtRegno)) begin
               dataOut[k*WORD_SIZE +: WORD_SIZE] = dataIn;
               busy[k] = 1'b0;
            end
`else
`endif
         end
      end
   end

endmodule
